// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encodings, FSM states,
// status-flag bundle and the opcode legality check.
package alu_pkg;

    localparam int unsigned OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [OPCODE_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [OPCODE_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [OPCODE_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [OPCODE_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [OPCODE_W-1:0] ALU_SHL  = 4'b0110;
    localparam logic [OPCODE_W-1:0] ALU_SHR  = 4'b0111;
    localparam logic [OPCODE_W-1:0] ALU_SRA  = 4'b1000;
    localparam logic [OPCODE_W-1:0] ALU_SLT  = 4'b1001;
    localparam logic [OPCODE_W-1:0] ALU_SLTU = 4'b1010;
    localparam logic [OPCODE_W-1:0] ALU_MUL  = 4'b1011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
        logic illegal;
    } alu_flags_t;

    // True for every opcode the ALU implements.
    function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
            ALU_SHL, ALU_SHR, ALU_SRA, ALU_SLT, ALU_SLTU,
            ALU_MUL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier returning the low WIDTH bits of op_a*op_b.
//   start   : load operands (one-cycle pulse)
//   done    : combinational, high in the final iteration cycle
//   product : combinational, valid while done is high
module alu_mul_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic [WIDTH-1:0] partial;
    logic             last;

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    // Bit 0's partial product is folded into the load, so cnt tracks the
    // multiplier bit being consumed and the last bit lands when cnt hits WIDTH-1.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        partial  = mplier_q[0] ? mcand_q : '0;
        last     = active_q && (cnt_q == CNT_W'(WIDTH - 1));

        if (start) begin
            mcand_d  = op_a << 1;
            mplier_d = op_b >> 1;
            acc_d    = op_b[0] ? op_a : '0;
            cnt_d    = CNT_W'(1);
            active_d = 1'b1;
        end else if (active_q) begin
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last) begin
                active_d = 1'b0;
            end
        end
    end

    assign done    = last;
    assign product = acc_q + partial;

endmodule

// File: rtl/alu_pipe_seq.sv
// Registered ALU with valid/ready handshake and a multi-cycle multiply.
//   in_valid/in_ready/opcode/operand_0/operand_1 : request side
//   out_valid/out_ready/result/flag_*            : registered result side
module alu_pipe_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [WIDTH-1:0]    operand_0,
    input  logic [WIDTH-1:0]    operand_1,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                flag_zero,
    output logic                flag_carry,
    output logic                flag_ovf,
    output logic                flag_illegal
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    alu_flags_t       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;
    logic             ready_en_q, ready_en_d;

    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   alu_res;
    alu_flags_t         alu_flags;

    alu_mul_seq #(
        .WIDTH (WIDTH),
        .CNT_W (SHAMT_W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .op_a    (operand_0),
        .op_b    (operand_1),
        .done    (mul_done),
        .product (mul_product)
    );

    // ready_en holds in_ready low until the first edge after reset release.
    assign in_ready = ready_en_q && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle operation datapath
    always_comb begin
        sum       = {1'b0, operand_0} + {1'b0, operand_1};
        diff      = {1'b0, operand_0} - {1'b0, operand_1};
        shamt     = operand_1[SHAMT_W-1:0];
        alu_res   = '0;
        alu_flags = '0;
        case (opcode)
            ALU_ADD: begin
                alu_res         = sum[WIDTH-1:0];
                alu_flags.carry = sum[WIDTH];
                alu_flags.ovf   = (operand_0[WIDTH-1] == operand_1[WIDTH-1]) &&
                                  (sum[WIDTH-1] != operand_0[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res         = diff[WIDTH-1:0];
                alu_flags.carry = diff[WIDTH];
                alu_flags.ovf   = (operand_0[WIDTH-1] != operand_1[WIDTH-1]) &&
                                  (diff[WIDTH-1] != operand_0[WIDTH-1]);
            end
            ALU_AND:  alu_res = operand_0 & operand_1;
            ALU_OR:   alu_res = operand_0 | operand_1;
            ALU_XOR:  alu_res = operand_0 ^ operand_1;
            ALU_SHL:  alu_res = operand_0 << shamt;
            ALU_SHR:  alu_res = operand_0 >> shamt;
            ALU_SRA:  alu_res = WIDTH'($signed(operand_0) >>> shamt);
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand_0) < $signed(operand_1))};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (operand_0 < operand_1)};
            default:  alu_res = '0;
        endcase
        alu_flags.illegal = !is_legal(opcode);
        alu_flags.zero    = (alu_res == '0);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            ready_en_q  <= ready_en_d;
        end
    end

    // Handshake FSM: next state, output register load, multiplier launch
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        ready_en_d  = 1'b1;
        mul_start   = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (opcode == ALU_MUL) begin
                        mul_start = 1'b1;
                        state_d   = ST_BUSY;
                    end else begin
                        result_d    = alu_res;
                        flags_d     = alu_flags;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    result_d      = mul_product;
                    flags_d       = '0;
                    flags_d.zero  = (mul_product == '0);
                    out_valid_d   = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_valid    = out_valid_q;
    assign result       = result_q;
    assign flag_zero    = flags_q.zero;
    assign flag_carry   = flags_q.carry;
    assign flag_ovf     = flags_q.ovf;
    assign flag_illegal = flags_q.illegal;

endmodule

// File: tb/tb_alu_pipe_seq.sv
// Directed self-checking bench for alu_pipe_seq (WIDTH = 32).
module tb_alu_pipe_seq;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   opcode;
    logic [W-1:0] operand_0;
    logic [W-1:0] operand_1;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_zero;
    logic         flag_carry;
    logic         flag_ovf;
    logic         flag_illegal;

    int n_tests;
    int n_fail;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   fl;   // {zero, carry, ovf, illegal}
    } vec_t;

    alu_pipe_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opcode       (opcode),
        .operand_0    (operand_0),
        .operand_1    (operand_1),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .flag_zero    (flag_zero),
        .flag_carry   (flag_carry),
        .flag_ovf     (flag_ovf),
        .flag_illegal (flag_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] flags();
        return {flag_zero, flag_carry, flag_ovf, flag_illegal};
    endfunction

    // Present one request at the current negedge; returns at the negedge after acceptance.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        opcode    = op;
        operand_0 = a;
        operand_1 = b;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; operand_0 = '0; operand_1 = '0;
        @(negedge clk); @(negedge clk);
        n_tests++;
        if ({result, flags(), out_valid, in_ready} !== {32'h0, 4'b0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got res=%h fl=%b ov=%b rdy=%b, want all zero",
                     result, flags(), out_valid, in_ready);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 0 before first edge", in_ready);
        end
        @(posedge clk); @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after_edge: got %b want 1", in_ready);
        end
    endtask

    task automatic test_alu_ops();
        vec_t v [15];
        v = '{
            '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100},
            '{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0010},
            '{ALU_SUB,  32'h00000001, 32'h00000002, 32'hFFFFFFFF, 4'b0100},
            '{ALU_SRA,  32'h80000000, 32'h00000024, 32'hF8000000, 4'b0000},
            '{ALU_SHL,  32'h00000001, 32'h0000001F, 32'h80000000, 4'b0000},
            '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000},
            '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1000},
            '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0010},
            '{ALU_AND,  32'hF0F0FFFF, 32'h0FF0F00F, 32'h00F0F00F, 4'b0000},
            '{ALU_OR,   32'h12340000, 32'h00005678, 32'h12345678, 4'b0000},
            '{ALU_SHR,  32'h80000000, 32'h0000003F, 32'h00000001, 4'b0000},
            '{4'hF,     32'h00000005, 32'h00000005, 32'h00000000, 4'b1001},
            '{ALU_XOR,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 4'b0000},
            '{4'h5,     32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1001},
            '{ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 4'b1000}
        };
        for (int i = 0; i < 15; i++) begin
            send(v[i].op, v[i].a, v[i].b);
            n_tests++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL alu[%0d]_latency: out_valid got %b want 1", i, out_valid);
            end
            n_tests++;
            if (result !== v[i].res) begin
                n_fail++;
                $display("FAIL alu[%0d]_result: got %h want %h", i, result, v[i].res);
            end
            n_tests++;
            if (flags() !== v[i].fl) begin
                n_fail++;
                $display("FAIL alu[%0d]_flags: got %b want %b", i, flags(), v[i].fl);
            end
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_idle: out_valid got %b want 0", out_valid);
        end
        send(ALU_ADD, 32'd20, 32'd22);
        n_tests++;
        if ({out_valid, result} !== {1'b1, 32'd42}) begin
            n_fail++;
            $display("FAIL lat_one: got ov=%b res=%h want ov=1 res=0000002a", out_valid, result);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_clear: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_mul();
        int bad;
        bad = 0;
        opcode = ALU_MUL; operand_0 = 32'h00010003; operand_1 = 32'h00000005;
        in_valid = 1'b1; out_ready = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_accept_ready: got %b want 1", in_ready);
        end
        @(posedge clk); @(negedge clk);
        // A different request is held through the whole multiply.
        opcode = ALU_ADD; operand_0 = 32'd2; operand_1 = 32'd3;
        for (int k = 1; k < 32; k++) begin
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL mul_busy: %0d busy cycles with out_valid/in_ready high, want 0", bad);
        end
        #1;
        n_tests++;
        if ({out_valid, result, flags(), in_ready} !== {1'b1, 32'h0005000F, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL mul_result_at_32: got ov=%b res=%h fl=%b rdy=%b want 1 0005000f 0000 0",
                     out_valid, result, flags(), in_ready);
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_idle_ready: got %b want 1", in_ready);
        end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if ({out_valid, result} !== {1'b1, 32'd5}) begin
            n_fail++;
            $display("FAIL mul_held_req: got ov=%b res=%h want 1 00000005", out_valid, result);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        out_ready = 1'b0;
        send(ALU_ADD, 32'd5, 32'd7);
        for (int k = 0; k < 3; k++) begin
            #1;
            if (out_valid !== 1'b1 || result !== 32'h0000000C || in_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d stalled cycles not holding 0000000c, want 0", bad);
        end
        n_tests++;
        if ({out_valid, result} !== {1'b1, 32'h0000000C}) begin
            n_fail++;
            $display("FAIL bp_after_stall: got ov=%b res=%h want 1 0000000c", out_valid, result);
        end
        out_ready = 1'b1;
        opcode = ALU_XOR; operand_0 = 32'hF0F0F0F0; operand_1 = 32'hFFFFFFFF;
        in_valid = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b want 1", in_ready);
        end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if ({out_valid, result} !== {1'b1, 32'h0F0F0F0F}) begin
            n_fail++;
            $display("FAIL bp_no_bubble: got ov=%b res=%h want 1 0f0f0f0f", out_valid, result);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp [3];
        exp = '{32'd3, 32'd7, 32'h000000FF};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin opcode = ALU_ADD; operand_0 = 32'd1;  operand_1 = 32'd2;  end
                1: begin opcode = ALU_SUB; operand_0 = 32'd10; operand_1 = 32'd3;  end
                default: begin opcode = ALU_OR; operand_0 = 32'hF0; operand_1 = 32'h0F; end
            endcase
            @(posedge clk); @(negedge clk);
            n_tests++;
            if ({out_valid, result} !== {1'b1, exp[i]}) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got ov=%b res=%h want 1 %h", i, out_valid, result, exp[i]);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mul();
        int bad;
        bad = 0;
        out_ready = 1'b1;
        send(ALU_MUL, 32'd3, 32'd3);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, in_ready, result} !== {1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL rst_mid_mul: got ov=%b rdy=%b res=%h want 0 0 0", out_valid, in_ready, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_release: got ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready);
        end
        for (int k = 0; k < 40; k++) begin
            if (out_valid !== 1'b0 || result !== 32'h0) bad++;
            @(negedge clk);
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rst_stale: %0d cycles with stale output, want 0", bad);
        end
        send(ALU_ADD, 32'd1, 32'd1);
        n_tests++;
        if ({out_valid, result} !== {1'b1, 32'd2}) begin
            n_fail++;
            $display("FAIL rst_recover: got ov=%b res=%h want 1 00000002", out_valid, result);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_alu_ops();
        test_latency();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
